// File: rtl/ysyx_22040759_rdaxi_if.sv
// AXI4 read-channel bundle (AR + R) between the read master and a slave.
//   master modport: drives AR payload/valid and R ready; samples AR ready and R payload.
//   slave  modport: the mirror image, used by memory models and interconnect.
interface ysyx_22040759_rdaxi_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    parameter int USER_W = 1
);
    logic              ar_ready;
    logic              ar_valid;
    logic [ADDR_W-1:0] ar_addr;
    logic [2:0]        ar_prot;
    logic [ID_W-1:0]   ar_id;
    logic [USER_W-1:0] ar_user;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size;
    logic [1:0]        ar_burst;
    logic              ar_lock;
    logic [3:0]        ar_cache;
    logic [3:0]        ar_qos;
    logic              r_ready;
    logic              r_valid;
    logic [1:0]        r_resp;
    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic [ID_W-1:0]   r_id;
    logic [USER_W-1:0] r_user;

    modport master (
        input  ar_ready,
        output ar_valid, ar_addr, ar_prot, ar_id, ar_user, ar_len, ar_size,
               ar_burst, ar_lock, ar_cache, ar_qos,
        output r_ready,
        input  r_valid, r_resp, r_data, r_last, r_id, r_user
    );

    modport slave (
        output ar_ready,
        input  ar_valid, ar_addr, ar_prot, ar_id, ar_user, ar_len, ar_size,
               ar_burst, ar_lock, ar_cache, ar_qos,
        input  r_ready,
        output r_valid, r_resp, r_data, r_last, r_id, r_user
    );
endinterface

// File: rtl/ysyx_22040759_rdaxi.sv
// Single-outstanding AXI4 read master for the CPU load/fetch path.
// Latches one request (address, size, signedness), issues a single-beat AR,
// extracts the addressed bytes from the last R beat, zero/sign-extends them to
// 64 bits and presents the result with a one-cycle rd_data_valid_o pulse.
// Ports:
//   clk, rst (async, active-low)
//   rd_addr_valid_i/rd_addr_i/rd_size_i/rd_signed_i : load request
//   rd_busy_o, rd_data_valid_o, rd_data_o, rd_resp_err_o : load result
//   axi : AR/R channels (master modport)
// Optional: define AXI_RD_TIMEOUT_EN to add a watchdog that abandons a read
// after RD_TIMEOUT_CYCLES cycles in ADDR/READ and returns data 0 with error.
module ysyx_22040759_rdaxi #(
    parameter int AXI_DATA_WIDTH    = 64,
    parameter int AXI_ADDR_WIDTH    = 64,
    parameter int AXI_ID_WIDTH      = 4,
    parameter int AXI_USER_WIDTH    = 1,
    parameter int RD_TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_addr_valid_i,
    input  logic [63:0] rd_addr_i,
    input  logic [1:0]  rd_size_i,
    input  logic        rd_signed_i,
    output logic        rd_busy_o,
    output logic        rd_data_valid_o,
    output logic [63:0] rd_data_o,
    output logic        rd_resp_err_o,
    ysyx_22040759_rdaxi_if.master axi
);
    typedef enum logic [1:0] {IDLE, ADDR, READ, DONE} state_t;

    state_t      state, state_n;
    logic [63:0] addr_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [63:0] data_q;
    logic        err_q;
    logic        req_take;
    logic        r_last_hs;
    logic        to_hit;

    logic [AXI_DATA_WIDTH-1:0] sh;
    logic [63:0]               ext;

    assign req_take  = (state == IDLE) && rd_addr_valid_i;
    assign r_last_hs = (state == READ) && axi.r_valid && axi.r_last;

`ifdef AXI_RD_TIMEOUT_EN
    localparam int TO_W = ($clog2(RD_TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(RD_TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            to_cnt <= '0;
        else if (req_take)
            to_cnt <= '0;
        else if (state == ADDR || state == READ)
            to_cnt <= to_cnt + 1'b1;
    end

    assign to_hit = (state == ADDR || state == READ) && (to_cnt == TO_W'(RD_TIMEOUT_CYCLES));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (rd_addr_valid_i)                state_n = ADDR;
            ADDR: if (axi.ar_ready)                   state_n = READ;
            READ: if (axi.r_valid && axi.r_last)      state_n = DONE;
            DONE:                                     state_n = IDLE;
            default:                                  state_n = IDLE;
        endcase
        // Watchdog overrides a stuck handshake; the slave is left hanging.
        if (to_hit) state_n = DONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
        end else if (req_take) begin
            addr_q   <= rd_addr_i;
            size_q   <= rd_size_i;
            signed_q <= rd_signed_i;
        end
    end

    // Shifting the whole beat down leaves zeros above byte 7, which covers
    // misaligned accesses that run off the end of the 8-byte lane group.
    always_comb begin
        sh  = axi.r_data >> {addr_q[2:0], 3'b000};
        ext = sh[63:0];
        case (size_q)
            2'd0: ext = signed_q ? {{56{sh[7]}},  sh[7:0]}  : {56'b0, sh[7:0]};
            2'd1: ext = signed_q ? {{48{sh[15]}}, sh[15:0]} : {48'b0, sh[15:0]};
            2'd2: ext = signed_q ? {{32{sh[31]}}, sh[31:0]} : {32'b0, sh[31:0]};
            default: ext = sh[63:0];
        endcase
    end

    // Only the last beat lands in the result; a real last beat wins over a
    // watchdog expiry in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            err_q  <= 1'b0;
        end else if (r_last_hs) begin
            data_q <= ext;
            err_q  <= (axi.r_resp != 2'b00);
        end else if (to_hit) begin
            data_q <= '0;
            err_q  <= 1'b1;
        end
    end

    assign rd_busy_o       = (state != IDLE);
    assign rd_data_valid_o = (state == DONE);
    assign rd_data_o       = data_q;
    assign rd_resp_err_o   = err_q;

    assign axi.ar_valid = (state == ADDR);
    assign axi.ar_addr  = AXI_ADDR_WIDTH'({addr_q[63:3], 3'b000});
    assign axi.ar_prot  = 3'b000;
    assign axi.ar_id    = {AXI_ID_WIDTH{1'b0}};
    assign axi.ar_user  = {AXI_USER_WIDTH{1'b0}};
    assign axi.ar_len   = 8'd0;
    assign axi.ar_size  = {1'b0, size_q};
    assign axi.ar_burst = 2'b01;
    assign axi.ar_lock  = 1'b0;
    assign axi.ar_cache = 4'b0010;
    assign axi.ar_qos   = 4'd0;
    assign axi.r_ready  = (state == READ);
endmodule
